bcd_2421_sequencer: RTL

Multi-digit BCD-to-2421 (Aiken) conversion controller. It accepts a packed word of `NDIGITS` BCD digits over a valid/ready handshake and time-shares a single 4-bit combinational BCD-to-2421 converter across the digits, one digit per clock, least-significant digit first. It then presents the assembled 2421 word and an invalid-digit flag on an output valid/ready handshake. It sits between the keypad/BCD capture logic and the display/code-output stage.

---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_to_2421_digit.sv | 25 ++
 rtl/bcd_2421_sequencer.sv | 98 +++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-2421 sequencer.
// FSM state enum, largest legal BCD digit, code written for bad digits.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_e;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] CODE_INVALID = 4'b0000;

endpackage

// File: rtl/bcd_to_2421_digit.sv
// Combinational single-digit BCD to 2421 (Aiken) converter.
// Ports: bcd in, code out, digit_err high for digits above 9.
module bcd_to_2421_digit
  import bcd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [3:0] code,
  output logic       digit_err
);

  always_comb begin
    code      = CODE_INVALID;
    digit_err = 1'b0;
    unique case (1'b1)
      (bcd <= 4'd4): code = bcd;
      (bcd > BCD_MAX): begin
        code      = CODE_INVALID;
        digit_err = 1'b1;
      end
      // 5..9 map to 1011..1111, i.e. the digit plus six
      default: code = bcd + 4'd6;
    endcase
  end

endmodule

// File: rtl/bcd_2421_sequencer.sv
// Multi-digit BCD-to-2421 sequencer sharing one digit converter, LSD first.
// Ports: in_valid/in_ready/in_bcd in, out_valid/out_ready/out_code/out_err out.
module bcd_2421_sequencer
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NDIGITS-1:0] in_bcd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NDIGITS-1:0] out_code,
  output logic                 out_err
);

  localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIGITS - 1);

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NDIGITS-1:0][3:0] src_q, src_d;
  logic [NDIGITS-1:0][3:0] code_q, code_d;
  logic acc_q, acc_d;
  logic err_q, err_d;

  logic [3:0] dig_bcd;
  logic [3:0] dig_code;
  logic       dig_err;

  assign dig_bcd = src_q[cnt_q];

  bcd_to_2421_digit u_digit (
    .bcd      (dig_bcd),
    .code     (dig_code),
    .digit_err(dig_err)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    code_d  = code_q;
    acc_d   = acc_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          src_d   = in_bcd;
          cnt_d   = '0;
          acc_d   = 1'b0;
          state_d = CONV;
        end
      end
      CONV: begin
        code_d[cnt_q] = dig_code;
        acc_d         = acc_q | dig_err;
        // out_err only moves once the whole word is known
        if (cnt_q == LAST) begin
          err_d   = acc_q | dig_err;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      code_q  <= '0;
      acc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      code_q  <= code_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_code  = code_q;
  assign out_err   = err_q;

endmodule
